// File: rtl/bus_region_decoder.sv
// Address-region decoder for a strobe-based CPU bus: one-hot chip selects,
// per-region wait states and direction guards, with timeout-driven bus error.
module bus_region_decoder #(
  parameter int NUM_REGIONS = 16,
  parameter int ADDR_W      = 24,
  parameter int WAIT_W      = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [ADDR_W-1:0]             cpu_a,
  input  logic                          cpu_as_n,
  input  logic                          cpu_rw,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_mask,
  input  logic [NUM_REGIONS*WAIT_W-1:0] region_wait,
  input  logic [2*NUM_REGIONS-1:0]      region_dir,
  input  logic                          ext_wait,
  output logic [NUM_REGIONS-1:0]        cs,
  output logic [4:0]                    hit_idx,
  output logic                          dtack_n,
  output logic                          berr_n,
  output logic [2:0]                    state_dbg
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ACK  = 3'd2,
    ST_TMO  = 3'd3,
    ST_BERR = 3'd4
  } state_t;

  // Bus handshake: an access starts on the first edge that samples cpu_as_n
  // low while armed, and ends only on an edge that samples cpu_as_n high.
  state_t              state_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [TW-1:0]       tmo_cnt_q;
  logic                armed_q;

  logic [NUM_REGIONS-1:0] hit_vec;
  logic                   match_any;
  logic [4:0]             match_idx;
  logic [WAIT_W-1:0]      match_wait;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
    logic [1:0] dir;
    logic       dir_ok;
    assign dir    = region_dir[2*g +: 2];
    assign dir_ok = (dir == 2'b00) || (dir == 2'b01 && cpu_rw) || (dir == 2'b10 && !cpu_rw);
    assign hit_vec[g] = dir_ok &&
      (((cpu_a ^ region_base[g*ADDR_W +: ADDR_W]) & region_mask[g*ADDR_W +: ADDR_W]) == '0);
  end

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    match_any  = 1'b0;
    match_idx  = '0;
    match_wait = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        match_any  = 1'b1;
        match_idx  = 5'(i);
        match_wait = region_wait[i*WAIT_W +: WAIT_W];
      end
    end
  end

  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cs         <= '0;
      hit_idx    <= '0;
      dtack_n    <= 1'b1;
      berr_n     <= 1'b1;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      armed_q    <= 1'b0;
    end else begin
      // A strobe still low at reset release must be seen high before it counts.
      if (cpu_as_n) armed_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!cpu_as_n && armed_q) begin
            armed_q   <= 1'b0;
            tmo_cnt_q <= '0;
            if (match_any) begin
              cs         <= NUM_REGIONS'(1) << match_idx;
              hit_idx    <= match_idx;
              wait_cnt_q <= match_wait;
              state_q    <= ST_WAIT;
            end else begin
              hit_idx    <= '0;
              wait_cnt_q <= '0;
              state_q    <= ST_TMO;
            end
          end
        end
        ST_WAIT: begin
          if (cpu_as_n) begin
            cs      <= '0;
            state_q <= ST_IDLE;
          end else if (wait_cnt_q != '0) begin
            wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
          end else if (!ext_wait) begin
            dtack_n <= 1'b0;
            state_q <= ST_ACK;
          end else if (tmo_cnt_q == TMO_LAST) begin
            cs      <= '0;
            berr_n  <= 1'b0;
            state_q <= ST_BERR;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        ST_ACK: begin
          if (cpu_as_n) begin
            cs      <= '0;
            dtack_n <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_TMO: begin
          if (cpu_as_n) begin
            state_q <= ST_IDLE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            berr_n  <= 1'b0;
            state_q <= ST_BERR;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        ST_BERR: begin
          if (cpu_as_n) begin
            berr_n  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_region_decoder.sv
// Directed bench for bus_region_decoder: expected responses are queued by the
// driver and checked by a monitor whenever dtack_n or berr_n asserts.
module tb_bus_region_decoder;
  localparam int NR = 16;
  localparam int AW = 24;
  localparam int WW = 4;
  localparam int TO = 64;
  localparam int RW = 31;

  logic              clk;
  logic              reset_n;
  logic [AW-1:0]     cpu_a;
  logic              cpu_as_n;
  logic              cpu_rw;
  logic [NR*AW-1:0]  region_base;
  logic [NR*AW-1:0]  region_mask;
  logic [NR*WW-1:0]  region_wait;
  logic [2*NR-1:0]   region_dir;
  logic              ext_wait;
  logic [NR-1:0]     cs;
  logic [4:0]        hit_idx;
  logic              dtack_n;
  logic              berr_n;
  logic [2:0]        state_dbg;

  bus_region_decoder #(.NUM_REGIONS(NR), .ADDR_W(AW), .WAIT_W(WW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_as_n(cpu_as_n), .cpu_rw(cpu_rw),
    .region_base(region_base), .region_mask(region_mask), .region_wait(region_wait),
    .region_dir(region_dir), .ext_wait(ext_wait), .cs(cs), .hit_idx(hit_idx),
    .dtack_n(dtack_n), .berr_n(berr_n), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int strobe_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // kind 1 = acknowledge, 2 = bus error; latency counted from the accepting edge
  function automatic logic [RW-1:0] pack(input logic [1:0] kind, input logic [NR-1:0] c,
                                         input logic [4:0] idx, input int lat);
    return {kind, c, idx, 8'(lat)};
  endfunction

  logic dtack_prev = 1'b1;
  logic berr_prev  = 1'b1;
  always @(negedge clk) begin
    logic [RW-1:0] got;
    if (reset_n && ((!dtack_n && dtack_prev) || (!berr_n && berr_prev))) begin
      got = pack(!berr_n ? 2'd2 : 2'd1, cs, hit_idx, cyc - strobe_cyc);
      if (exp_q.size() == 0) check("unexpected_resp", {1'b0, got}, 32'h0);
      else check("resp", {1'b0, got}, {1'b0, exp_q.pop_front()});
    end
    dtack_prev = dtack_n;
    berr_prev  = berr_n;
  end

  // ---------------- driver tasks ----------------
  task automatic set_region(input int i, input logic [AW-1:0] b, input logic [AW-1:0] m,
                            input logic [WW-1:0] w, input logic [1:0] d);
    region_base[i*AW +: AW] = b;
    region_mask[i*AW +: AW] = m;
    region_wait[i*WW +: WW] = w;
    region_dir[2*i +: 2]    = d;
  endtask

  task automatic start_access(input logic [AW-1:0] a, input logic rw);
    @(negedge clk);
    cpu_a      = a;
    cpu_rw     = rw;
    cpu_as_n   = 1'b0;
    strobe_cyc = cyc + 1;
  endtask

  task automatic wait_resp(input int budget, input string name);
    int n = 0;
    while (dtack_n && berr_n && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_responded"}, {31'b0, !(dtack_n && berr_n)}, 32'd1);
  endtask

  task automatic end_access(input string name);
    @(negedge clk);
    cpu_as_n = 1'b1;
    @(negedge clk);
    check({name, "_rel_dtack"}, {31'b0, dtack_n}, 32'd1);
    check({name, "_rel_berr"}, {31'b0, berr_n}, 32'd1);
    check({name, "_rel_cs"}, {16'b0, cs}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n     = 1'b0;
    cpu_a       = '0;
    cpu_as_n    = 1'b0;
    cpu_rw      = 1'b1;
    ext_wait    = 1'b0;
    region_base = '0;
    region_mask = '0;
    region_wait = '0;
    region_dir  = '1;
    set_region(0, 24'h000000, 24'hFC0000, 4'd0, 2'b00);
    set_region(1, 24'h070000, 24'hFF0000, 4'd1, 2'b00);
    set_region(2, 24'h0A0000, 24'hFFC000, 4'd3, 2'b00);
    set_region(3, 24'h0E0000, 24'hFF0000, 4'd0, 2'b10);
    set_region(4, 24'h100000, 24'hFF0000, 4'd2, 2'b00);
    set_region(5, 24'h070000, 24'hFF8000, 4'd5, 2'b00);
    set_region(6, 24'h200000, 24'hFF0000, 4'd1, 2'b01);

    repeat (2) @(negedge clk);
    check("rst_cs", {16'b0, cs}, 32'd0);
    check("rst_hit", {27'b0, hit_idx}, 32'd0);
    check("rst_dtack", {31'b0, dtack_n}, 32'd1);
    check("rst_berr", {31'b0, berr_n}, 32'd1);
    check("rst_state", {29'b0, state_dbg}, 32'd0);

    // strobe already low at release must not start an access
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rel_low_as_cs", {16'b0, cs}, 32'd0);
    check("rel_low_as_state", {29'b0, state_dbg}, 32'd0);
    cpu_as_n = 1'b1;
    @(negedge clk);

    // region 0, wait 0 read
    start_access(24'h012345, 1'b1);
    exp_q.push_back(pack(2'd1, 16'h0001, 5'd0, 1));
    @(negedge clk);
    check("r0_cs_after_k", {16'b0, cs}, 32'h0001);
    wait_resp(10, "r0");
    end_access("r0");

    // region 2, wait 3 write; address and region config change mid-access
    start_access(24'h0A1000, 1'b0);
    exp_q.push_back(pack(2'd1, 16'h0004, 5'd2, 4));
    @(negedge clk);
    cpu_a = 24'h000000;
    region_wait[2*WW +: WW] = 4'd0;
    region_dir[2*2 +: 2]    = 2'b11;
    wait_resp(20, "r2");
    region_wait[2*WW +: WW] = 4'd3;
    region_dir[2*2 +: 2]    = 2'b00;
    end_access("r2");

    // overlap of regions 1 and 5: lowest index wins
    start_access(24'h070000, 1'b1);
    exp_q.push_back(pack(2'd1, 16'h0002, 5'd1, 2));
    wait_resp(20, "ovl");
    check("ovl_hit", {27'b0, hit_idx}, 32'd1);
    end_access("ovl");

    // read to a write-only region, nothing else matches: timeout
    start_access(24'h0E0000, 1'b1);
    exp_q.push_back(pack(2'd2, 16'h0000, 5'd0, TO));
    @(negedge clk);
    check("wo_rd_cs", {16'b0, cs}, 32'd0);
    wait_resp(TO + 10, "wo_rd");
    end_access("wo_rd");

    // write to the same region is fine
    start_access(24'h0E0000, 1'b0);
    exp_q.push_back(pack(2'd1, 16'h0008, 5'd3, 1));
    wait_resp(10, "wo_wr");
    end_access("wo_wr");

    // read-only region: write errors, read acknowledges
    start_access(24'h200010, 1'b0);
    exp_q.push_back(pack(2'd2, 16'h0000, 5'd0, TO));
    wait_resp(TO + 10, "ro_wr");
    end_access("ro_wr");
    start_access(24'h200010, 1'b1);
    exp_q.push_back(pack(2'd1, 16'h0040, 5'd6, 2));
    wait_resp(10, "ro_rd");
    end_access("ro_rd");

    // wait-2 region with ext_wait high for edges k+1..k+10
    ext_wait = 1'b1;
    start_access(24'h100004, 1'b1);
    exp_q.push_back(pack(2'd1, 16'h0010, 5'd4, 11));
    repeat (11) @(negedge clk);
    check("ext_stalled_dtack", {31'b0, dtack_n}, 32'd1);
    ext_wait = 1'b0;
    wait_resp(5, "ext");
    end_access("ext");

    // reset pulse during WAIT clears cs asynchronously
    start_access(24'h0A1000, 1'b0);
    @(negedge clk);
    check("rstmid_cs_before", {16'b0, cs}, 32'h0004);
    #3 reset_n = 1'b0;
    #1;
    check("rstmid_cs_async", {16'b0, cs}, 32'd0);
    check("rstmid_dtack", {31'b0, dtack_n}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rstmid_no_restart", {16'b0, cs}, 32'd0);
    check("rstmid_state", {29'b0, state_dbg}, 32'd0);
    cpu_as_n = 1'b1;
    repeat (2) @(negedge clk);

    // abort in WAIT after one cycle
    start_access(24'h0A1000, 1'b0);
    @(negedge clk);
    cpu_as_n = 1'b1;
    @(negedge clk);
    check("abort_cs", {16'b0, cs}, 32'd0);
    check("abort_state", {29'b0, state_dbg}, 32'd0);
    repeat (6) @(negedge clk);
    check("abort_dtack", {31'b0, dtack_n}, 32'd1);
    check("abort_berr", {31'b0, berr_n}, 32'd1);

    // abort during timeout count
    start_access(24'h300000, 1'b1);
    repeat (5) @(negedge clk);
    check("tmo_state", {29'b0, state_dbg}, 32'd3);
    cpu_as_n = 1'b1;
    @(negedge clk);
    check("tmo_abort_state", {29'b0, state_dbg}, 32'd0);
    repeat (TO + 4) @(negedge clk);
    check("tmo_abort_berr", {31'b0, berr_n}, 32'd1);

    // one more normal access after all the aborts
    start_access(24'h070010, 1'b0);
    exp_q.push_back(pack(2'd1, 16'h0002, 5'd1, 2));
    wait_resp(10, "final");
    end_access("final");

    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_region_decoder.md
BUS_REGION_DECODER -- requirements
Module: bus_region_decoder

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 16, number of decodable address regions (1..32).
REQ-002 SHALL have parameter ADDR_W, default 24, CPU address width.
REQ-003 SHALL have parameter WAIT_W, default 4, width of per-region wait-state count.
REQ-004 SHALL have parameter TIMEOUT, default 64, cycles before bus error on an unmapped or stalled access.
REQ-005 SHALL have port clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port cpu_a  in  ADDR_W  CPU address.
REQ-008 SHALL have port cpu_as_n  in  1  address strobe, active low.
REQ-009 SHALL have port cpu_rw  in  1  1 = read, 0 = write.
REQ-010 SHALL have port region_base  in  NUM_REGIONS*ADDR_W  per-region base address; region i at bits [i*ADDR_W +: ADDR_W].
REQ-011 SHALL have port region_mask  in  NUM_REGIONS*ADDR_W  per-region compare mask; 1 = bit compared.
REQ-012 SHALL have port region_wait  in  NUM_REGIONS*WAIT_W  per-region wait states.
REQ-013 SHALL have port region_dir  in  2*NUM_REGIONS  per-region direction: 00 any, 01 read only, 10 write only, 11 disabled.
REQ-014 SHALL have port ext_wait  in  1  device stall; holds off acknowledge while high.
REQ-015 SHALL have port cs  out  NUM_REGIONS  registered one-hot chip selects.
REQ-016 SHALL have port hit_idx  out  5  index of the selected region.
REQ-017 SHALL have port dtack_n  out  1  data acknowledge, active low.
REQ-018 SHALL have port berr_n  out  1  bus error, active low.

Function
REQ-019 Region i SHALL match when ((cpu_a ^ base_i) & mask_i) == 0 and region_dir_i permits cpu_rw; 11 never matches.
REQ-020 When several regions match, the lowest index SHALL win; cs SHALL never have more than one bit set.
REQ-021 FSM states SHALL be IDLE, WAIT, ACK, TMO, BERR.
REQ-022 IDLE: on the first edge with cpu_as_n = 0, the block SHALL latch cpu_a and cpu_rw and evaluate the match.
- Match: set cs bit and hit_idx; load counter with region_wait; go to WAIT.
- No match: clear counter; go to TMO.
REQ-023 WAIT: counter == 0 and ext_wait = 0 SHALL go to ACK and drive dtack_n low.
- Counter nonzero: decrement each edge.
- ext_wait = 1 with counter at 0: hold, incrementing the timeout counter.
REQ-024 Timing: AS sampled low at edge k gives cs high after edge k and dtack_n low after edge k+1+W, where W = region wait and ext_wait stays low.
REQ-025 ACK: cs and dtack_n SHALL hold until cpu_as_n is sampled high; then cs = 0, dtack_n = 1, and the FSM returns to IDLE on that same edge.
REQ-026 TMO: the counter SHALL increment each edge. At TIMEOUT-1 the FSM SHALL go to BERR with berr_n low. A WAIT stalled by ext_wait for TIMEOUT cycles SHALL also go to BERR with cs cleared.
REQ-027 BERR: berr_n SHALL hold low until cpu_as_n is sampled high, then return to IDLE with berr_n = 1.
REQ-028 Abort: cpu_as_n high during WAIT or TMO SHALL return to IDLE next edge with cs = 0 and no dtack_n or berr_n pulse.
REQ-029 Back-to-back: after returning to IDLE, a new strobe SHALL NOT be accepted on that same edge; at least one IDLE cycle separates accesses.
REQ-030 The decision SHALL be made only from latched cpu_a and cpu_rw; address changes after acceptance SHALL be ignored.
REQ-031 Changes to region_* during an access SHALL NOT affect that access except through the wait count already loaded.
REQ-032 The wait counter SHALL be WAIT_W bits wide; the timeout counter SHALL be clog2(TIMEOUT)+1 bits wide; neither SHALL wrap.

Reset
REQ-033 While reset_n = 0: FSM = IDLE, cs = 0, hit_idx = 0, dtack_n = 1, berr_n = 1, all counters = 0.
REQ-034 Reset asserted mid-access SHALL immediately deassert cs and dtack_n and abort the access. After release, the FSM SHALL wait for a fresh falling strobe: if cpu_as_n is low at release, it SHALL first be sampled high.

Verification
REQ-035 Region 0: base 0x000000, mask 0xFC0000, wait 0. Read 0x012345 -> cs = 0x0001 after edge k; dtack_n low after edge k+1.
REQ-036 Region 2: base 0x0A0000, mask 0xFFC000, wait 3. Write 0x0A1000 -> dtack_n low after edge k+4; released one edge after cpu_as_n rises.
REQ-037 Regions 1 and 5 both match 0x070000 -> cs = 0x0002, hit_idx = 1.
REQ-038 Read 0x0E0000 to a region with dir 10, no other match -> no cs; berr_n low after edge k+TIMEOUT (k+64).
REQ-039 Wait 2 region with ext_wait held high 10 cycles -> dtack_n low 1 edge after ext_wait falls. Separately, reset_n pulsed low in WAIT -> cs = 0 asynchronously; no dtack_n.
REQ-040 cpu_as_n raised in WAIT after 1 cycle -> IDLE next edge, cs = 0, dtack_n and berr_n stay 1.
